// File: rtl/axi_mem_master_pkg.sv
// Shared constants and FSM state encoding for the single-outstanding AXI memory initiator.
package axi_mem_master_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      RD_A,
      RD_D,
      WR_AW,
      WR_B
   } state_t;

endpackage

// File: rtl/axi_mem_master_if.sv
// AXI4-lite channel bundle between the memory initiator (master) and a responder (slave).
interface axi_mem_master_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64
);
   localparam int STRB_W = DATA_W / 8;

   logic [ADDR_W-1:0] araddr;
   logic              arvalid;
   logic              arready;
   logic [DATA_W-1:0] rdata;
   logic [1:0]        rresp;
   logic              rvalid;
   logic              rready;
   logic [ADDR_W-1:0] awaddr;
   logic              awvalid;
   logic              awready;
   logic [DATA_W-1:0] wdata;
   logic [STRB_W-1:0] wstrb;
   logic              wvalid;
   logic              wready;
   logic [1:0]        bresp;
   logic              bvalid;
   logic              bready;

   modport master (
      output araddr, arvalid, input arready,
      input rdata, rresp, rvalid, output rready,
      output awaddr, awvalid, input awready,
      output wdata, wstrb, wvalid, input wready,
      input bresp, bvalid, output bready
   );

   modport slave (
      input araddr, arvalid, output arready,
      output rdata, rresp, rvalid, input rready,
      input awaddr, awvalid, output awready,
      input wdata, wstrb, wvalid, output wready,
      output bresp, bvalid, input bready
   );

endinterface

// File: rtl/axi_mem_master_wr_join.sv
// Joins independent AW and W handshakes; both_done is combinational and includes the current cycle.
// Latency: 0 cycles from last handshake to both_done; flags clear on the cycle both_done fires.
module axi_mem_master_wr_join (
   input  logic aclk,
   input  logic aresetn,
   input  logic aw_hs,
   input  logic w_hs,
   output logic both_done
);

   logic aw_done;
   logic w_done;

   assign both_done = (aw_done | aw_hs) & (w_done | w_hs);

   always_ff @(posedge aclk) begin
      if (!aresetn || both_done) begin
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else begin
         if (aw_hs) aw_done <= 1'b1;
         if (w_hs)  w_done  <= 1'b1;
      end
   end

endmodule

// File: rtl/axi_mem_master.sv
// CPU request -> AXI4-lite AR/R or AW/W/B, one transaction in flight, registered outputs.
// Latency 3 cycles accept-to-resp_valid with a zero-wait responder; req_ready low while busy or pulsing resp_valid.
module axi_mem_master
   import axi_mem_master_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 64,
   parameter int TMO_CYC = 1024,
   localparam int STRB_W = DATA_W / 8
) (
   input  logic                aclk,
   input  logic                aresetn,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_wen,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [STRB_W-1:0]   req_wstrb,
   output logic                resp_valid,
   output logic [DATA_W-1:0]   resp_rdata,
   output logic                resp_err,
   output logic                tmo_flag,
   axi_mem_master_if.master    axi
);

   localparam int CNT_W = (TMO_CYC > 1) ? $clog2(TMO_CYC + 1) : 1;

   state_t            state_q, state_nxt;
   logic [ADDR_W-1:0] addr_q, addr_nxt;
   logic [DATA_W-1:0] wdata_q, wdata_nxt;
   logic [STRB_W-1:0] wstrb_q, wstrb_nxt;
   logic              arvalid_q, arvalid_nxt;
   logic              rready_q, rready_nxt;
   logic              awvalid_q, awvalid_nxt;
   logic              wvalid_q, wvalid_nxt;
   logic              bready_q, bready_nxt;
   logic              resp_valid_q, resp_valid_nxt;
   logic [DATA_W-1:0] resp_rdata_q, resp_rdata_nxt;
   logic              resp_err_q, resp_err_nxt;
   logic              tmo_q, tmo_nxt;
   logic [CNT_W-1:0]  cnt_q, cnt_nxt;

   logic ar_hs, r_hs, aw_hs, w_hs, b_hs, both_done;

   assign ar_hs = arvalid_q & axi.arready;
   assign r_hs  = rready_q  & axi.rvalid;
   assign aw_hs = awvalid_q & axi.awready;
   assign w_hs  = wvalid_q  & axi.wready;
   assign b_hs  = bready_q  & axi.bvalid;

   axi_mem_master_wr_join u_wr_join (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .aw_hs     (aw_hs),
      .w_hs      (w_hs),
      .both_done (both_done)
   );

   assign req_ready   = (state_q == IDLE) && !resp_valid_q;
   assign resp_valid  = resp_valid_q;
   assign resp_rdata  = resp_rdata_q;
   assign resp_err    = resp_err_q;
   assign tmo_flag    = tmo_q;

   assign axi.araddr  = addr_q;
   assign axi.arvalid = arvalid_q;
   assign axi.rready  = rready_q;
   assign axi.awaddr  = addr_q;
   assign axi.awvalid = awvalid_q;
   assign axi.wdata   = wdata_q;
   assign axi.wstrb   = wstrb_q;
   assign axi.wvalid  = wvalid_q;
   assign axi.bready  = bready_q;

   always_comb begin
      state_nxt      = state_q;
      addr_nxt       = addr_q;
      wdata_nxt      = wdata_q;
      wstrb_nxt      = wstrb_q;
      arvalid_nxt    = arvalid_q;
      rready_nxt     = rready_q;
      awvalid_nxt    = awvalid_q;
      wvalid_nxt     = wvalid_q;
      bready_nxt     = bready_q;
      resp_valid_nxt = 1'b0;
      resp_rdata_nxt = resp_rdata_q;
      resp_err_nxt   = resp_err_q;
      tmo_nxt        = tmo_q;
      cnt_nxt        = cnt_q;

      case (state_q)
         IDLE: begin
            if (req_valid && req_ready) begin
               addr_nxt  = req_addr;
               wdata_nxt = req_wdata;
               wstrb_nxt = req_wstrb;
               if (req_wen) begin
                  awvalid_nxt = 1'b1;
                  wvalid_nxt  = 1'b1;
                  state_nxt   = WR_AW;
               end else begin
                  arvalid_nxt = 1'b1;
                  state_nxt   = RD_A;
               end
            end
         end
         RD_A: begin
            if (ar_hs) begin
               arvalid_nxt = 1'b0;
               rready_nxt  = 1'b1;
               state_nxt   = RD_D;
            end
         end
         RD_D: begin
            if (r_hs) begin
               resp_rdata_nxt = axi.rdata;
               resp_err_nxt   = (axi.rresp != RESP_OKAY);
               resp_valid_nxt = 1'b1;
               rready_nxt     = 1'b0;
               state_nxt      = IDLE;
            end
         end
         WR_AW: begin
            if (aw_hs) awvalid_nxt = 1'b0;
            if (w_hs)  wvalid_nxt  = 1'b0;
            if (both_done) begin
               bready_nxt = 1'b1;
               state_nxt  = WR_B;
            end
         end
         WR_B: begin
            if (b_hs) begin
               resp_err_nxt   = (axi.bresp != RESP_OKAY);
               resp_valid_nxt = 1'b1;
               bready_nxt     = 1'b0;
               state_nxt      = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase

      // Watchdog only flags; the transaction keeps running so the bus protocol is never violated.
      if (state_q == IDLE) begin
         cnt_nxt = '0;
      end else if (TMO_CYC != 0) begin
         if (cnt_q != CNT_W'(TMO_CYC)) cnt_nxt = cnt_q + CNT_W'(1);
         if (cnt_q == CNT_W'(TMO_CYC - 1)) tmo_nxt = 1'b1;
      end
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         wdata_q      <= '0;
         wstrb_q      <= '0;
         arvalid_q    <= 1'b0;
         rready_q     <= 1'b0;
         awvalid_q    <= 1'b0;
         wvalid_q     <= 1'b0;
         bready_q     <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
         tmo_q        <= 1'b0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_nxt;
         addr_q       <= addr_nxt;
         wdata_q      <= wdata_nxt;
         wstrb_q      <= wstrb_nxt;
         arvalid_q    <= arvalid_nxt;
         rready_q     <= rready_nxt;
         awvalid_q    <= awvalid_nxt;
         wvalid_q     <= wvalid_nxt;
         bready_q     <= bready_nxt;
         resp_valid_q <= resp_valid_nxt;
         resp_rdata_q <= resp_rdata_nxt;
         resp_err_q   <= resp_err_nxt;
         tmo_q        <= tmo_nxt;
         cnt_q        <= cnt_nxt;
      end
   end

endmodule

// File: tb/tb_axi_mem_master.sv
// Directed bench for axi_mem_master: reads, writes, stalls, error response, mid-transaction reset, watchdog.
module tb_axi_mem_master;

   logic        aclk;
   logic        aresetn;
   logic        req_valid;
   logic        req_ready;
   logic        req_wen;
   logic [31:0] req_addr;
   logic [63:0] req_wdata;
   logic [7:0]  req_wstrb;
   logic        resp_valid;
   logic [63:0] resp_rdata;
   logic        resp_err;
   logic        tmo_flag;

   int checks = 0;
   int errors = 0;

   logic [63:0] mem [0:3];

   axi_mem_master_if #(.ADDR_W(32), .DATA_W(64)) bus ();

   axi_mem_master #(.ADDR_W(32), .DATA_W(64), .TMO_CYC(8)) dut (
      .aclk       (aclk),
      .aresetn    (aresetn),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_wen    (req_wen),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_wstrb  (req_wstrb),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .tmo_flag   (tmo_flag),
      .axi        (bus)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   // Small responder memory: byte-merges on every W handshake, addressed by awaddr[4:3].
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         mem[0] <= 64'h0123_4567_89AB_CDEF;
         mem[1] <= 64'hFEDC_BA98_7654_3210;
         mem[2] <= 64'hAAAA_BBBB_CCCC_DDDD;
         mem[3] <= 64'h5555_6666_7777_8888;
      end else if (bus.wvalid && bus.wready) begin
         for (int i = 0; i < 8; i++)
            if (bus.wstrb[i]) mem[bus.awaddr[4:3]][8*i +: 8] <= bus.wdata[8*i +: 8];
      end
   end

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic wen, input logic [31:0] addr, input logic [63:0] wd, input logic [7:0] ws);
      req_valid = 1'b1;
      req_wen   = wen;
      req_addr  = addr;
      req_wdata = wd;
      req_wstrb = ws;
      tick();
      req_valid = 1'b0;
   endtask

   initial begin
      aresetn      = 1'b0;
      req_valid    = 1'b0;
      req_wen      = 1'b0;
      req_addr     = '0;
      req_wdata    = '0;
      req_wstrb    = '0;
      bus.arready  = 1'b0;
      bus.rvalid   = 1'b0;
      bus.rdata    = '0;
      bus.rresp    = 2'b00;
      bus.awready  = 1'b0;
      bus.wready   = 1'b0;
      bus.bvalid   = 1'b0;
      bus.bresp    = 2'b00;
      tick();
      tick();
      aresetn = 1'b1;

      // Reset state
      chk("rst_req_ready", 64'(req_ready), 64'd1);
      chk("rst_arvalid", 64'(bus.arvalid), 64'd0);
      chk("rst_awvalid", 64'(bus.awvalid), 64'd0);
      chk("rst_wvalid", 64'(bus.wvalid), 64'd0);
      chk("rst_rready_bready", 64'({bus.rready, bus.bready}), 64'd0);
      chk("rst_resp", 64'({resp_valid, resp_err, tmo_flag}), 64'd0);
      chk("rst_rdata", resp_rdata, 64'd0);
      chk("rst_araddr", 64'(bus.araddr), 64'd0);

      // Zero-wait read of 0x8000_0000
      bus.arready = 1'b1;
      issue(1'b0, 32'h8000_0000, 64'd0, 8'h00);
      chk("rd0_arvalid_t1", 64'(bus.arvalid), 64'd1);
      chk("rd0_araddr_t1", 64'(bus.araddr), 64'h8000_0000);
      chk("rd0_req_ready_busy", 64'(req_ready), 64'd0);
      tick();
      chk("rd0_arvalid_t2", 64'(bus.arvalid), 64'd0);
      chk("rd0_rready_t2", 64'(bus.rready), 64'd1);
      bus.arready = 1'b0;
      bus.rvalid  = 1'b1;
      bus.rdata   = mem[0];
      tick();
      chk("rd0_resp_valid_t3", 64'(resp_valid), 64'd1);
      chk("rd0_rdata", resp_rdata, 64'h0123_4567_89AB_CDEF);
      chk("rd0_err", 64'(resp_err), 64'd0);
      chk("rd0_rready_drop", 64'(bus.rready), 64'd0);
      chk("rd0_req_ready_pulse", 64'(req_ready), 64'd0);
      bus.rvalid = 1'b0;
      tick();
      chk("rd0_pulse_end", 64'(resp_valid), 64'd0);
      chk("rd0_req_ready_back", 64'(req_ready), 64'd1);

      // Stalled read: arready low 3 cycles, rvalid 2 cycles late
      issue(1'b0, 32'h8000_0008, 64'd0, 8'h00);
      for (int i = 0; i < 3; i++) begin
         chk("rd1_arvalid_hold", 64'(bus.arvalid), 64'd1);
         chk("rd1_araddr_stable", 64'(bus.araddr), 64'h8000_0008);
         tick();
      end
      bus.arready = 1'b1;
      chk("rd1_arvalid_t4", 64'(bus.arvalid), 64'd1);
      tick();
      bus.arready = 1'b0;
      chk("rd1_arvalid_drop", 64'(bus.arvalid), 64'd0);
      for (int i = 0; i < 2; i++) begin
         chk("rd1_rready_wait", 64'(bus.rready), 64'd1);
         chk("rd1_no_resp", 64'(resp_valid), 64'd0);
         tick();
      end
      bus.rvalid = 1'b1;
      bus.rdata  = mem[1];
      tick();
      bus.rvalid = 1'b0;
      chk("rd1_resp_valid", 64'(resp_valid), 64'd1);
      chk("rd1_rdata", resp_rdata, 64'hFEDC_BA98_7654_3210);
      chk("rd1_tmo_7cyc", 64'(tmo_flag), 64'd0);
      tick();
      chk("rd1_single_pulse", 64'(resp_valid), 64'd0);

      // Unexpected bvalid while idle is ignored
      bus.bvalid = 1'b1;
      tick();
      bus.bvalid = 1'b0;
      chk("stray_b_bready", 64'(bus.bready), 64'd0);
      chk("stray_b_resp", 64'(resp_valid), 64'd0);
      chk("stray_b_idle", 64'(req_ready), 64'd1);

      // Write with W accepted two cycles before AW
      issue(1'b1, 32'h8000_0010, 64'h1122_3344_5566_7788, 8'h0F);
      chk("wr0_awvalid_t1", 64'(bus.awvalid), 64'd1);
      chk("wr0_wvalid_t1", 64'(bus.wvalid), 64'd1);
      chk("wr0_awaddr", 64'(bus.awaddr), 64'h8000_0010);
      chk("wr0_wdata", bus.wdata, 64'h1122_3344_5566_7788);
      chk("wr0_wstrb", 64'(bus.wstrb), 64'h0F);
      bus.wready = 1'b1;
      tick();
      bus.wready = 1'b0;
      chk("wr0_wvalid_drop", 64'(bus.wvalid), 64'd0);
      chk("wr0_awvalid_hold", 64'(bus.awvalid), 64'd1);
      chk("wr0_bready_early", 64'(bus.bready), 64'd0);
      tick();
      chk("wr0_awvalid_hold2", 64'(bus.awvalid), 64'd1);
      chk("wr0_bready_early2", 64'(bus.bready), 64'd0);
      bus.awready = 1'b1;
      tick();
      bus.awready = 1'b0;
      chk("wr0_awvalid_drop", 64'(bus.awvalid), 64'd0);
      chk("wr0_bready", 64'(bus.bready), 64'd1);
      bus.bvalid = 1'b1;
      bus.bresp  = 2'b00;
      tick();
      bus.bvalid = 1'b0;
      chk("wr0_resp_valid", 64'(resp_valid), 64'd1);
      chk("wr0_err", 64'(resp_err), 64'd0);
      chk("wr0_bready_drop", 64'(bus.bready), 64'd0);
      chk("wr0_rdata_kept", resp_rdata, 64'hFEDC_BA98_7654_3210);
      chk("wr0_mem_merge", mem[2], 64'hAAAA_BBBB_5566_7788);
      tick();

      // Write with SLVERR, AW and W in the same cycle
      bus.awready = 1'b1;
      bus.wready  = 1'b1;
      issue(1'b1, 32'h8000_0018, 64'hCAFE_F00D_0000_1111, 8'hFF);
      chk("wr1_both_valid", 64'({bus.awvalid, bus.wvalid}), 64'd3);
      tick();
      bus.awready = 1'b0;
      bus.wready  = 1'b0;
      chk("wr1_both_drop", 64'({bus.awvalid, bus.wvalid}), 64'd0);
      chk("wr1_bready_join", 64'(bus.bready), 64'd1);
      bus.bvalid = 1'b1;
      bus.bresp  = 2'b10;
      tick();
      bus.bvalid = 1'b0;
      bus.bresp  = 2'b00;
      chk("wr1_resp_valid", 64'(resp_valid), 64'd1);
      chk("wr1_err", 64'(resp_err), 64'd1);
      chk("wr1_mem_full", mem[3], 64'hCAFE_F00D_0000_1111);
      tick();

      // Following read returns OKAY and clears resp_err
      bus.arready = 1'b1;
      issue(1'b0, 32'h8000_0018, 64'd0, 8'h00);
      tick();
      bus.arready = 1'b0;
      bus.rvalid  = 1'b1;
      bus.rresp   = 2'b00;
      bus.rdata   = mem[3];
      tick();
      bus.rvalid = 1'b0;
      chk("rd2_resp_valid", 64'(resp_valid), 64'd1);
      chk("rd2_err_clear", 64'(resp_err), 64'd0);
      chk("rd2_rdata", resp_rdata, 64'hCAFE_F00D_0000_1111);
      tick();

      // Reset asserted while in RD_D
      bus.arready = 1'b1;
      issue(1'b0, 32'h8000_0000, 64'd0, 8'h00);
      tick();
      bus.arready = 1'b0;
      chk("rst_mid_in_rd_d", 64'(bus.rready), 64'd1);
      aresetn = 1'b0;
      tick();
      chk("rst_mid_valids", 64'({bus.arvalid, bus.awvalid, bus.wvalid}), 64'd0);
      chk("rst_mid_readies", 64'({bus.rready, bus.bready}), 64'd0);
      chk("rst_mid_no_resp", 64'(resp_valid), 64'd0);
      aresetn    = 1'b1;
      bus.rvalid = 1'b1;
      bus.rdata  = 64'hDEAD_DEAD_DEAD_DEAD;
      tick();
      chk("rst_mid_req_ready", 64'(req_ready), 64'd1);
      chk("rst_mid_stray_r", 64'(resp_valid), 64'd0);
      chk("rst_mid_rready", 64'(bus.rready), 64'd0);
      tick();
      bus.rvalid = 1'b0;
      chk("rst_mid_still_idle", 64'({resp_valid, req_ready}), 64'd1);
      chk("rst_mid_rdata", resp_rdata, 64'd0);

      // Watchdog: arready stuck low 10 cycles with TMO_CYC=8
      issue(1'b0, 32'h8000_0000, 64'd0, 8'h00);
      for (int i = 1; i <= 8; i++) begin
         chk("tmo_not_yet", 64'(tmo_flag), 64'd0);
         tick();
      end
      chk("tmo_set", 64'(tmo_flag), 64'd1);
      chk("tmo_arvalid_held", 64'(bus.arvalid), 64'd1);
      tick();
      chk("tmo_arvalid_held2", 64'(bus.arvalid), 64'd1);
      bus.arready = 1'b1;
      tick();
      bus.arready = 1'b0;
      chk("tmo_ar_done", 64'(bus.rready), 64'd1);
      bus.rvalid = 1'b1;
      bus.rdata  = mem[0];
      tick();
      bus.rvalid = 1'b0;
      chk("tmo_completes", 64'(resp_valid), 64'd1);
      chk("tmo_rdata", resp_rdata, 64'h0123_4567_89AB_CDEF);
      chk("tmo_sticky", 64'(tmo_flag), 64'd1);
      tick();
      chk("tmo_sticky_idle", 64'(tmo_flag), 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
